// File: rtl/rbcp_responder_pkg.sv
// -----------------------------------------------------------------------------
// rbcp_responder_pkg
// Shared constants for the RBCP register responder: the address-window width
// and the register offsets inside the window, plus a helper that maps a
// control-register offset onto its bit position in the packed ctrl vector.
// -----------------------------------------------------------------------------
package rbcp_responder_pkg;

    // The register window spans 2**WIN_W bytes.
    localparam int unsigned WIN_W = 5;

    typedef logic [WIN_W-1:0] ofs_t;

    localparam ofs_t OFS_ID        = 5'h00;
    localparam ofs_t OFS_STATUS    = 5'h01;
    localparam ofs_t OFS_WCNT      = 5'h02;
    localparam ofs_t OFS_PULSE     = 5'h03;
    localparam ofs_t OFS_CTRL_BASE = 5'h10;

    localparam int unsigned CTRL_BYTES = 16;

    // Bit index of the low bit of control byte (ofs - OFS_CTRL_BASE).
    function automatic logic [6:0] ctrl_lsb(input ofs_t ofs);
        return {ofs[3:0], 3'b000};
    endfunction

endpackage

// File: rtl/rbcp_responder.sv
// -----------------------------------------------------------------------------
// rbcp_responder
// SiTCP RBCP slave exposing a 32-byte register window at BASE_ADDR:
//   0x00      RO  ID_BYTE
//   0x01      RO  status_in, captured on the strobe edge
//   0x02      RO  count of accepted writes (wraps)
//   0x03      WO  write emits a one-cycle command pulse on pulse_out
//   0x04-0x0F     reserved (reads 0, writes only bump the counter)
//   0x10-0x1F RW  control bytes, driven on ctrl_out
//
// Ports
//   SYSCLK       system clock, rising edge
//   sitcp_rst    asynchronous active-high reset
//   rbcp_active  RBCP transaction in progress
//   rbcp_addr    access address
//   rbcp_wd      write data
//   rbcp_we      write strobe (one cycle)
//   rbcp_re      read strobe (one cycle)
//   rbcp_ack     acknowledge, one cycle after an accepted strobe
//   rbcp_rd      read data, zero whenever rbcp_ack is low
//   status_in    user status byte
//   ctrl_out     control bytes; byte k at [8k+7:8k] maps to offset 0x10+k
//   pulse_out    command pulse, coincident with the ack of a 0x03 write
// -----------------------------------------------------------------------------
module rbcp_responder
    import rbcp_responder_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]   ID_BYTE   = 8'hA5,
    parameter logic [127:0] CTRL_INIT = 128'h0
) (
    input  logic         SYSCLK,
    input  logic         sitcp_rst,
    input  logic         rbcp_active,
    input  logic [31:0]  rbcp_addr,
    input  logic [7:0]   rbcp_wd,
    input  logic         rbcp_we,
    input  logic         rbcp_re,
    output logic         rbcp_ack,
    output logic [7:0]   rbcp_rd,
    input  logic [7:0]   status_in,
    output logic [127:0] ctrl_out,
    output logic [7:0]   pulse_out
);

    ofs_t         ofs;
    logic         in_window;
    logic         accept;
    logic         wr_ok;
    logic         rd_ok;
    logic         is_ctrl;
    logic [7:0]   rd_next;

    logic         ack_q;
    logic [7:0]   rd_q;
    logic [7:0]   pulse_q;
    logic [7:0]   wcnt_q;
    logic [127:0] ctrl_q;

    assign ofs       = rbcp_addr[WIN_W-1:0];
    assign in_window = (rbcp_addr[31:WIN_W] == BASE_ADDR[31:WIN_W]);
    assign accept    = (rbcp_we | rbcp_re) & rbcp_active & in_window;
    // A simultaneous we/re is treated as a write only.
    assign wr_ok     = accept & rbcp_we;
    assign rd_ok     = accept & ~rbcp_we;
    assign is_ctrl   = (ofs >= OFS_CTRL_BASE);

    // Read mux over the current register contents. Because writes land on
    // the strobe edge, a read one cycle after a write already sees new data.
    always_comb begin
        // NOTE: default first so every path assigns rd_next and no latch is inferred.
        rd_next = 8'h00;
        if (is_ctrl) begin
            rd_next = ctrl_q[ctrl_lsb(ofs) +: 8];
        end else begin
            case (ofs)
                OFS_ID:     rd_next = ID_BYTE;
                OFS_STATUS: rd_next = status_in;
                OFS_WCNT:   rd_next = wcnt_q;
                default:    rd_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or posedge sitcp_rst) begin
        if (sitcp_rst) begin
            // NOTE: the control bytes are real flops with a defined power-up value, so they are reset like any other state.
            ctrl_q  <= CTRL_INIT;
            wcnt_q  <= 8'h00;
            ack_q   <= 1'b0;
            rd_q    <= 8'h00;
            pulse_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            ack_q   <= accept;
            rd_q    <= rd_ok ? rd_next : 8'h00;
            pulse_q <= (wr_ok && ofs == OFS_PULSE) ? rbcp_wd : 8'h00;
            if (wr_ok) begin
                wcnt_q <= wcnt_q + 8'h01;
                if (is_ctrl) begin
                    ctrl_q[ctrl_lsb(ofs) +: 8] <= rbcp_wd;
                end
            end
        end
    end

    assign rbcp_ack  = ack_q;
    assign rbcp_rd   = rd_q;
    assign pulse_out = pulse_q;
    assign ctrl_out  = ctrl_q;

endmodule

// File: tb/tb_rbcp_responder.sv
// -----------------------------------------------------------------------------
// tb_rbcp_responder
// Scoreboard bench: the stimulus process updates a byte-level model of the
// register map and queues the response each accepted strobe must produce;
// a monitor on the falling edge pops and compares whenever an ack is due and
// otherwise requires ack, rd and pulse to be quiet.
// -----------------------------------------------------------------------------
module tb_rbcp_responder;

    localparam logic [31:0]  BASE      = 32'h0000_0000;
    localparam logic [7:0]   ID        = 8'hA5;
    localparam logic [127:0] CTRL_INIT = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rbcp_active = 1'b0;
    logic [31:0]  rbcp_addr = '0;
    logic [7:0]   rbcp_wd = '0;
    logic         rbcp_we = 1'b0;
    logic         rbcp_re = 1'b0;
    logic         rbcp_ack;
    logic [7:0]   rbcp_rd;
    logic [7:0]   status_in = '0;
    logic [127:0] ctrl_out;
    logic [7:0]   pulse_out;

    rbcp_responder #(
        .BASE_ADDR (BASE),
        .ID_BYTE   (ID),
        .CTRL_INIT (CTRL_INIT)
    ) dut (
        .SYSCLK      (clk),
        .sitcp_rst   (rst),
        .rbcp_active (rbcp_active),
        .rbcp_addr   (rbcp_addr),
        .rbcp_wd     (rbcp_wd),
        .rbcp_we     (rbcp_we),
        .rbcp_re     (rbcp_re),
        .rbcp_ack    (rbcp_ack),
        .rbcp_rd     (rbcp_rd),
        .status_in   (status_in),
        .ctrl_out    (ctrl_out),
        .pulse_out   (pulse_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] rd;
        logic [7:0] pulse;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_ctrl[16];
    logic [7:0] m_cnt;

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_ctrl[k] = CTRL_INIT[8*k +: 8];
        m_cnt = 8'h00;
    endtask

    function automatic logic [127:0] model_ctrl();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = m_ctrl[k];
        return v;
    endfunction

    // Apply one cycle of bus inputs (reset released) and record what the
    // responder owes for it.
    task automatic step(input logic we, input logic re, input logic act,
                        input logic [31:0] addr, input logic [7:0] wd);
        exp_t       e;
        int         o;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        rbcp_we     = we;
        rbcp_re     = re;
        rbcp_active = act;
        rbcp_addr   = addr;
        rbcp_wd     = wd;
        status_in   = 8'($urandom);
        if ((we || re) && act && addr[31:5] == BASE[31:5]) begin
            o       = int'(addr[4:0]);
            e.due   = cyc + 1;
            e.rd    = 8'h00;
            e.pulse = 8'h00;
            if (we) begin
                m_cnt = m_cnt + 8'd1;
                if (o == 3)  e.pulse = wd;
                if (o >= 16) m_ctrl[o-16] = wd;
            end else begin
                if (o == 0)       e.rd = ID;
                else if (o == 1)  e.rd = status_in;
                else if (o == 2)  e.rd = m_cnt;
                else if (o >= 16) e.rd = m_ctrl[o-16];
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1, 32'h0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b1, a, 8'h00);
    endtask

    task automatic hold_reset(input int n);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        rbcp_we = 1'b0;
        rbcp_re = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            check("reset_quiet", {rbcp_ack, rbcp_rd, pulse_out}, 17'h0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("ack",   rbcp_ack,  1'b1);
            check("rd",    rbcp_rd,   e.rd);
            check("pulse", pulse_out, e.pulse);
        end else begin
            check("idle_quiet", {rbcp_ack, rbcp_rd, pulse_out}, 17'h0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("ctrl_reset", ctrl_out, CTRL_INIT);

        // ID read on the first edge after reset release
        rd(32'h0000_0000);
        idle(2);

        // control write then immediate read-back, then counter
        wr(32'h0000_0013, 8'h5C);
        rd(32'h0000_0013);
        rd(32'h0000_0002);
        idle(2);
        check("ctrl_13", ctrl_out[31:24], 8'h5C);
        check("ctrl_all", ctrl_out, model_ctrl());

        // command pulse and its read-as-zero
        wr(32'h0000_0003, 8'h81);
        idle(1);
        rd(32'h0000_0003);
        idle(2);

        // rejected strobes: outside window, inactive, far address
        rd(32'h0000_0020);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0000, 8'h00);
        step(1'b1, 1'b0, 1'b1, 32'h8000_0011, 8'hEE);
        step(1'b1, 1'b0, 1'b0, 32'h0000_0011, 8'hEE);
        idle(2);
        check("ctrl_untouched", ctrl_out, model_ctrl());

        // writes to RO offsets do not change them
        wr(32'h0000_0000, 8'h11);
        wr(32'h0000_0001, 8'h22);
        wr(32'h0000_0002, 8'h33);
        rd(32'h0000_0000);
        rd(32'h0000_0002);
        rd(32'h0000_0001);
        idle(2);

        // counter wrap: 256 reserved-offset writes, back to back
        for (int i = 0; i < 256; i++) wr(32'h0000_0005, 8'(i));
        rd(32'h0000_0002);
        rd(32'h0000_0005);
        idle(2);

        // we+re together: write wins, rd stays zero
        step(1'b1, 1'b1, 1'b1, 32'h0000_0010, 8'h3A);
        rd(32'h0000_0010);
        idle(2);
        check("ctrl_10", ctrl_out[7:0], 8'h3A);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic        we, re, act;
            int          k;
            k   = $urandom_range(0, 15);
            a   = {27'h0, 5'($urandom)};
            if (k == 0) a = a | 32'h0000_0020;
            if (k == 1) a = $urandom | 32'h0100_0000;
            act = ($urandom_range(0, 9) != 0);
            we  = $urandom_range(0, 2) == 0;
            re  = $urandom_range(0, 2) != 0;
            step(we, re, act, a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);
        check("ctrl_random", ctrl_out, model_ctrl());

        // reset with an ack pending
        wr(32'h0000_0012, 8'h77);
        hold_reset(3);
        check("ctrl_in_reset", ctrl_out, CTRL_INIT);
        rd(32'h0000_0002);
        rd(32'h0000_0012);
        idle(3);
        check("ctrl_after_reset", ctrl_out, CTRL_INIT);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
